// File: rtl/dispatch_demux_1x4.sv
// rtl/dispatch_demux_1x4.sv - registered 1-to-4 valid/ready demux with per-lane output register; DISPATCH_DEMUX_COUNT_EN adds lane_count
module dispatch_demux_1x4 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data
`ifdef DISPATCH_DEMUX_COUNT_EN
  ,
  output logic [31:0]          lane_count
`endif
);

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  lane_state_t      state_q [4];
  lane_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [3:0]       load;
  logic [3:0]       drain;

  // Expose lane registers as flat output vectors
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i]                = (state_q[i] == LANE_FULL);
      out_data[i*WIDTH +: WIDTH]  = data_q[i];
    end
  end

  // Only the addressed lane gates acceptance; in_valid is deliberately not used
  always_comb begin
    in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]);
  end

  // Per-lane load/drain decode and next state; load wins over a same-cycle drain
  always_comb begin
    load  = '0;
    drain = '0;
    for (int i = 0; i < 4; i++) begin
      drain[i]   = out_valid[i] & out_ready[i];
      load[i]    = in_valid & in_ready & (in_sel == 2'(i));
      state_d[i] = state_q[i];
      if (flush) begin
        state_d[i] = LANE_EMPTY;
      end else if (load[i]) begin
        state_d[i] = LANE_FULL;
      end else if (drain[i]) begin
        state_d[i] = LANE_EMPTY;
      end
    end
  end

  // Lane state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) state_q[i] <= LANE_EMPTY;
    end else begin
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
    end
  end

  // Lane data registers; only the loaded lane is written, flush leaves data alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end

`ifdef DISPATCH_DEMUX_COUNT_EN
  logic [7:0] cnt_q [4];

  // Saturating drain counters; flush does not clear them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  // Pack counters, lane i in bits [i*8 +: 8]
  always_comb begin
    lane_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  end
`endif

endmodule

// File: tb/tb_dispatch_demux_1x4.sv
// tb/tb_dispatch_demux_1x4.sv - randomized self-checking bench for dispatch_demux_1x4 against a lane-level model
module tb_dispatch_demux_1x4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
`ifdef DISPATCH_DEMUX_COUNT_EN
  logic [31:0]  lane_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: which lanes hold a payload, what payload, how many drains
  bit          mv  [4];
  logic [31:0] md  [4];
  int          cnt [4];

  dispatch_demux_1x4 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DISPATCH_DEMUX_COUNT_EN
    ,
    .lane_count(lane_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return !flush && (!mv[in_sel] || out_ready[in_sel]);
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = md[i];
    return d;
  endfunction

  function automatic logic [31:0] exp_count();
    logic [31:0] c;
    for (int i = 0; i < 4; i++) c[i*8 +: 8] = 8'(cnt[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; md[i] = '0; cnt[i] = 0;
    end
  endtask

  // Called at posedge+1: apply inputs and let them settle before the next edge
  task automatic drive(input bit v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy, input bit fl);
    in_valid = v; in_sel = sel; in_data = d; out_ready = ordy; flush = fl;
    #3;
  endtask

  // Advance one edge and move the model with it
  task automatic tick();
    bit          acc;
    bit          nv [4];
    logic [31:0] nd [4];
    acc = in_valid && model_ready();
    for (int i = 0; i < 4; i++) begin
      nv[i] = mv[i]; nd[i] = md[i];
      if (mv[i] && out_ready[i] && cnt[i] < 255) cnt[i]++;
      if (flush) nv[i] = 1'b0;
      else if (acc && in_sel == i) begin nv[i] = 1'b1; nd[i] = in_data; end
      else if (mv[i] && out_ready[i]) nv[i] = 1'b0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %h want 0", out_valid); end
    checks++;
    if (out_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_first_accept();
    drive(1'b1, 2'd2, 32'hA5A5_0001, 4'b0000, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL first_valid got %b want 0100", out_valid); end
    checks++;
    if (out_data !== {32'h0, 32'hA5A5_0001, 64'h0})
      begin errors++; $display("FAIL first_data got %h want lane2=a5a50001 others 0", out_data); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd2, 32'hDEAD_0002, 4'b0000, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_data[95:64] !== 32'hA5A5_0001)
      begin errors++; $display("FAIL stall_hold got %h want a5a50001", out_data[95:64]); end
    drive(1'b1, 2'd2, 32'hDEAD_0002, 4'b0100, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL passthru_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out_data[95:64] !== 32'hDEAD_0002)
      begin errors++; $display("FAIL passthru got valid %b data %h want 0100 dead0002", out_valid, out_data[95:64]); end
  endtask

  task automatic test_independent_lanes();
    logic [1:0] lanes [3];
    lanes[0] = 2'd0; lanes[1] = 2'd1; lanes[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, lanes[k], $urandom, 4'b0000, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready lane %0d got %b want 1", lanes[k], in_ready); end
      tick();
    end
    checks++;
    if (out_valid !== 4'b1111) begin errors++; $display("FAIL indep_valid got %b want 1111", out_valid); end
    checks++;
    if (out_data !== exp_data()) begin errors++; $display("FAIL indep_data got %h want %h", out_data, exp_data()); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    drive(1'b1, 2'd0, 32'h1111_2222, 4'b0000, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid got %b want 0000", out_valid); end
    d = $urandom;
    drive(1'b1, 2'd3, d, 4'b0000, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b1000 || out_data[127:96] !== d)
      begin errors++; $display("FAIL post_flush got valid %b data %h want 1000 %h", out_valid, out_data[127:96], d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    for (int l = 0; l < 3; l++) begin
      drive(1'b1, 2'(l), $urandom | 32'h1, 4'b0000, 1'b0);
      tick();
    end
    checks++;
    if (out_valid !== 4'b1111) begin errors++; $display("FAIL pre_reset_valid got %b want 1111", out_valid); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 128'h0)
      begin errors++; $display("FAIL async_reset got valid %b data %h want all 0", out_valid, out_data); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = $urandom;
    drive(1'b1, 2'd1, d, 4'b0000, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0010 || out_data[63:32] !== d)
      begin errors++; $display("FAIL post_reset got valid %b data %h want 0010 %h", out_valid, out_data[63:32], d); end
  endtask

  task automatic test_random();
    bit          v = 1'b0;
    logic [1:0]  sel = '0;
    logic [31:0] d = '0;
    bit          pend = 1'b0;
    bit          fl;
    bit          exp_rdy;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        sel = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      fl = ($urandom_range(0, 15) == 0);
      drive(v, sel, d, 4'($urandom), fl);
      exp_rdy = model_ready();
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", n, in_ready, exp_rdy); end
      pend = v && !exp_rdy;
      tick();
      checks++;
      if (out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", n, out_valid, exp_valid()); end
      checks++;
      if (out_data !== exp_data()) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", n, out_data, exp_data()); end
`ifdef DISPATCH_DEMUX_COUNT_EN
      checks++;
      if (lane_count !== exp_count()) begin errors++; $display("FAIL rand_count cyc %0d got %h want %h", n, lane_count, exp_count()); end
`endif
    end
  endtask

`ifdef DISPATCH_DEMUX_COUNT_EN
  task automatic test_counters();
    in_valid = 1'b0; flush = 1'b0; out_ready = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 301; n++) begin
      drive(1'b1, 2'd1, 32'(n), 4'b0010, 1'b0);
      tick();
    end
    checks++;
    if (lane_count !== 32'h0000_FF00) begin errors++; $display("FAIL count_sat got %h want 0000ff00", lane_count); end
    checks++;
    if (lane_count !== exp_count()) begin errors++; $display("FAIL count_model got %h want %h", lane_count, exp_count()); end
    drive(1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
    tick();
    checks++;
    if (lane_count !== 32'h0000_FF00 || out_valid !== 4'b0000)
      begin errors++; $display("FAIL count_flush got count %h valid %b want 0000ff00 0000", lane_count, out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_accept();
    test_backpressure();
    test_independent_lanes();
    test_flush();
    test_async_reset();
    test_random();
`ifdef DISPATCH_DEMUX_COUNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
